// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter: request record, FSM states, source ids.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  // One pending register-file write: destination index and value.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] dst;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE
  } wb_state_t;

  typedef enum logic {
    SRC_ALU,
    SRC_MEM
  } wb_src_t;

  // Round-robin helper: the requester that gets priority after 's' is served.
  function automatic wb_src_t other_src(input wb_src_t s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// Small synchronous FIFO holding write-back requests; head is visible combinationally.
// Latency: a pushed entry appears at the head the cycle after the push edge (no bypass).
// Backpressure: full blocks pushes even when a pop happens in the same cycle. WB_PENDING_EN exposes all slots.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  T     pushData,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
`ifdef WB_PENDING_EN
  ,
  output T     [DEPTH-1:0] slots,
  output logic [DEPTH-1:0] slotValid
`endif
);

  localparam int PW = $clog2(DEPTH);

  T     [DEPTH-1:0] mem;
  logic [PW:0]      wrPtr;
  logic [PW:0]      rdPtr;
  logic             pushOk;
  logic             popOk;

  // Extra pointer bit distinguishes full from empty when indices coincide.
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign pushOk = push && !full;
  assign popOk  = pop && !empty;
  assign head   = mem[rdPtr[PW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + (PW+1)'(1);
      if (popOk)  rdPtr <= rdPtr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr[PW-1:0]] <= pushData;
  end

`ifdef WB_PENDING_EN
  logic [PW:0]   count;
  logic [PW-1:0] offset;

  assign slots = mem;
  assign count = wrPtr - rdPtr;

  // A slot is live when its distance from the read index is below the occupancy.
  always_comb begin
    slotValid = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - rdPtr[PW-1:0];
      slotValid[i] = ({1'b0, offset} < count);
    end
  end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load write-backs into one register-file port with a clean one-cycle regWrite pulse.
// Latency: accepted at edge N -> address/data at N+1 -> regWrite high N+2..N+3; at most 1 write per 2 cycles.
// Backpressure: aluReady/memReady = FIFO not full. WB_PENDING_EN adds queryReg/pendingHit lookup.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              aluValid,
  output logic              aluReady,
  input  logic [ADDR_W-1:0] aluReg,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memValid,
  output logic              memReady,
  input  logic [ADDR_W-1:0] memReg,
  input  logic [DATA_W-1:0] memData,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic              busy
`ifdef WB_PENDING_EN
  ,
  input  logic [ADDR_W-1:0] queryReg,
  output logic              pendingHit
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t      aluHead, memHead, grantReq;
  logic      aluFull, aluEmpty, memFull, memEmpty;
  logic      aluPop, memPop;
  logic      aluElig, memElig, aluZero, memZero, anyElig;
  logic      grantFire;
  wb_src_t   grantSrc, rrPtr;
  wb_state_t state, nextState;

`ifdef WB_PENDING_EN
  req_t [FIFO_DEPTH-1:0] aluSlots, memSlots;
  logic [FIFO_DEPTH-1:0] aluSlotValid, memSlotValid;
`endif

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_alu_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (aluValid),
    .pushData  ('{dst: aluReg, data: aluData}),
    .pop       (aluPop),
    .full      (aluFull),
    .empty     (aluEmpty),
    .head      (aluHead)
`ifdef WB_PENDING_EN
    ,
    .slots     (aluSlots),
    .slotValid (aluSlotValid)
`endif
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_mem_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (memValid),
    .pushData  ('{dst: memReg, data: memData}),
    .pop       (memPop),
    .full      (memFull),
    .empty     (memEmpty),
    .head      (memHead)
`ifdef WB_PENDING_EN
    ,
    .slots     (memSlots),
    .slotValid (memSlotValid)
`endif
  );

  assign aluReady = !aluFull;
  assign memReady = !memFull;

  // r0 heads are never eligible; they are dropped instead of strobed.
  assign aluElig = !aluEmpty && (aluHead.dst != '0);
  assign memElig = !memEmpty && (memHead.dst != '0);
  assign aluZero = !aluEmpty && (aluHead.dst == '0);
  assign memZero = !memEmpty && (memHead.dst == '0);
  assign anyElig = aluElig || memElig;

  assign busy = !aluEmpty || !memEmpty || (state != IDLE);

  // Round-robin pick: priority holder wins a tie, a lone eligible head always wins.
  always_comb begin
    grantSrc = rrPtr;
    if (aluElig && !memElig) grantSrc = SRC_ALU;
    else if (memElig && !aluElig) grantSrc = SRC_MEM;
    grantReq = (grantSrc == SRC_ALU) ? aluHead : memHead;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state: a grant can only be taken from IDLE or at the end of a strobe.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (anyElig) nextState = SETUP;
      SETUP:   nextState = STROBE;
      STROBE:  nextState = anyElig ? SETUP : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs of the FSM: winner pop plus r0 discards, only in the decision states.
  always_comb begin
    aluPop    = 1'b0;
    memPop    = 1'b0;
    grantFire = 1'b0;
    if (state == IDLE || state == STROBE) begin
      grantFire = anyElig;
      aluPop    = aluZero || (anyElig && grantSrc == SRC_ALU);
      memPop    = memZero || (anyElig && grantSrc == SRC_MEM);
    end
  end

  // Write-port registers: address/data change only on entry to SETUP, strobe mirrors STROBE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rrPtr         <= SRC_ALU;
      writeRegister <= '0;
      writeData     <= '0;
      regWrite      <= 1'b0;
    end else begin
      if (grantFire) begin
        rrPtr         <= other_src(grantSrc);
        writeRegister <= grantReq.dst;
        writeData     <= grantReq.data;
      end
      regWrite <= (nextState == STROBE);
    end
  end

`ifdef WB_PENDING_EN
  // Hazard lookup: any queued entry or the in-flight write targeting queryReg (r0 never pends).
  always_comb begin
    pendingHit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (aluSlotValid[i] && aluSlots[i].dst == queryReg) pendingHit = 1'b1;
      if (memSlotValid[i] && memSlots[i].dst == queryReg) pendingHit = 1'b1;
    end
    if (state != IDLE && writeRegister == queryReg) pendingHit = 1'b1;
    if (queryReg == '0) pendingHit = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: table of per-cycle vectors plus multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stimulus honours ready; WB_PENDING_EN enables the pendingHit sequence.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          aluValid, aluReady, memValid, memReady;
  logic [AW-1:0] aluReg, memReg, writeRegister;
  logic [DW-1:0] aluData, memData, writeData;
  logic          regWrite, busy;
`ifdef WB_PENDING_EN
  logic [AW-1:0] queryReg;
  logic          pendingHit;
`endif

  int nVec = 0;
  int nMis = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .aluValid      (aluValid),
    .aluReady      (aluReady),
    .aluReg        (aluReg),
    .aluData       (aluData),
    .memValid      (memValid),
    .memReady      (memReady),
    .memReg        (memReg),
    .memData       (memData),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .busy          (busy)
`ifdef WB_PENDING_EN
    ,
    .queryReg      (queryReg),
    .pendingHit    (pendingHit)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
    aluValid = av; aluReg = ar; aluData = ad;
    memValid = mv; memReg = mr; memData = md;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic          av;
    logic [AW-1:0] ar;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] mr;
    logic [DW-1:0] md;
    logic          eAluRdy;
    logic          eMemRdy;
    logic          eRw;
    logic [AW-1:0] eWr;
    logic [DW-1:0] eWd;
    logic          eBusy;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int a, m, s, last, strobes;
    int exp2 [8];
    logic aAcc, mAcc;
    logic [AW-1:0] seen [$];

    //          av ar     ad            mv mr     md          aR mR rw wr     wd            busy
    // single ALU write r5
    tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,      1, 1, 0, 5'd0,  32'h0,        1};
    tbl[1]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 0, 5'd5,  32'hDEADBEEF, 1};
    tbl[2]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 1, 5'd5,  32'hDEADBEEF, 1};
    tbl[3]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 0, 5'd5,  32'hDEADBEEF, 0};
    // ALU pushes 3 while MEM r20 is in flight: full after 2, third waits for a pop
    tbl[4]  = '{0, 5'd0,  32'h0,        1, 5'd20, 32'h20,     1, 1, 0, 5'd5,  32'hDEADBEEF, 1};
    tbl[5]  = '{1, 5'd21, 32'h21,       0, 5'd0,  32'h0,      1, 1, 0, 5'd20, 32'h20,       1};
    tbl[6]  = '{1, 5'd22, 32'h22,       0, 5'd0,  32'h0,      0, 1, 1, 5'd20, 32'h20,       1};
    tbl[7]  = '{1, 5'd23, 32'h23,       0, 5'd0,  32'h0,      1, 1, 0, 5'd21, 32'h21,       1};
    tbl[8]  = '{1, 5'd23, 32'h23,       0, 5'd0,  32'h0,      0, 1, 1, 5'd21, 32'h21,       1};
    tbl[9]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 0, 5'd22, 32'h22,       1};
    tbl[10] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 1, 5'd22, 32'h22,       1};
    tbl[11] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 0, 5'd23, 32'h23,       1};
    tbl[12] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 1, 5'd23, 32'h23,       1};
    tbl[13] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 0, 5'd23, 32'h23,       0};
    // r0 load is discarded, r9 load is strobed
    tbl[14] = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h1234,   1, 1, 0, 5'd23, 32'h23,       1};
    tbl[15] = '{0, 5'd0,  32'h0,        1, 5'd9,  32'h99,     1, 1, 0, 5'd23, 32'h23,       1};
    tbl[16] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 0, 5'd9,  32'h99,       1};
    tbl[17] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 1, 5'd9,  32'h99,       1};
    tbl[18] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 1, 0, 5'd9,  32'h99,       0};

    // Reset state
    reset_n = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
`ifdef WB_PENDING_EN
    queryReg = '0;
`endif
    #12;
    check("rst.regWrite", regWrite, 0);
    check("rst.writeRegister", writeRegister, 0);
    check("rst.writeData", writeData, 0);
    check("rst.aluReady", aluReady, 1);
    check("rst.memReady", memReady, 1);
    check("rst.busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven per-cycle vectors
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md);
      tick();
      check($sformatf("v%0d.aluReady", i), aluReady, tbl[i].eAluRdy);
      check($sformatf("v%0d.memReady", i), memReady, tbl[i].eMemRdy);
      check($sformatf("v%0d.regWrite", i), regWrite, tbl[i].eRw);
      check($sformatf("v%0d.writeRegister", i), writeRegister, tbl[i].eWr);
      check($sformatf("v%0d.writeData", i), writeData, tbl[i].eWd);
      check($sformatf("v%0d.busy", i), busy, tbl[i].eBusy);
    end

    // Both streams continuously valid: strobes alternate, one every 2 cycles
    exp2 = '{1, 11, 2, 12, 3, 13, 4, 14};
    a = 0; m = 0; s = 0; last = -1;
    for (int c = 0; c < 60 && !(s == 8 && !busy); c++) begin
      drive(a < 4, 5'(1 + a), 32'h1000 + 32'(1 + a), m < 4, 5'(11 + m), 32'h1000 + 32'(11 + m));
      aAcc = aluValid && aluReady;
      mAcc = memValid && memReady;
      tick();
      if (aAcc) a++;
      if (mAcc) m++;
      if (regWrite) begin
        if (s < 8) begin
          check($sformatf("rr.reg%0d", s), writeRegister, exp2[s]);
          check($sformatf("rr.data%0d", s), writeData, 32'h1000 + exp2[s]);
        end
        if (last >= 0) check($sformatf("rr.gap%0d", s), c - last, 2);
        last = c;
        s++;
      end
    end
    check("rr.strobes", s, 8);
    check("rr.busyDone", busy, 0);
    drive(0, '0, '0, 0, '0, '0);

    // Reset during STROBE with two entries queued
    drive(1, 5'd1, 32'h51, 0, 5'd0, 32'h0);
    tick();
    drive(1, 5'd3, 32'h53, 1, 5'd2, 32'h52);
    tick();
    check("rst2.setupReg", writeRegister, 1);
    drive(0, '0, '0, 0, '0, '0);
    tick();
    check("rst2.strobe", regWrite, 1);
    check("rst2.busyBefore", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst2.regWriteDrop", regWrite, 0);
    check("rst2.busyCleared", busy, 0);
    check("rst2.addrCleared", writeRegister, 0);
    @(negedge clock);
    reset_n = 1'b1;
    strobes = 0;
    repeat (6) begin
      tick();
      if (regWrite) strobes++;
    end
    check("rst2.noStrobes", strobes, 0);
    check("rst2.idleBusy", busy, 0);
    drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h56);
    tick();
    drive(0, '0, '0, 0, '0, '0);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (regWrite) seen.push_back(writeRegister);
    end
    check("rst2.grantCount", seen.size(), 2);
    if (seen.size() == 2) begin
      check("rst2.firstAlu", seen[0], 5);
      check("rst2.secondMem", seen[1], 6);
    end

`ifdef WB_PENDING_EN
    // Pending lookup follows r7 from acceptance through its strobe
    queryReg = 5'd7;
    drive(1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
    #1;
    check("pend.beforeAccept", pendingHit, 0);
    tick();
    drive(0, '0, '0, 0, '0, '0);
    check("pend.queued", pendingHit, 1);
    tick();
    check("pend.setup", pendingHit, 1);
    queryReg = 5'd0;
    #1;
    check("pend.queryZero", pendingHit, 0);
    queryReg = 5'd7;
    #1;
    tick();
    check("pend.strobeRw", regWrite, 1);
    check("pend.strobe", pendingHit, 1);
    tick();
    check("pend.cleared", pendingHit, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
